rtc_init_sequencer: RTL

Parametrised power-up/initialisation sequencer for the RTC register interface. On a start request it replays a compile-time table of register address/data pairs and holds each pair on `address`/`data_mod` for a fixed number of clocks so the downstream bus-write controller can commit it. It extends the two-step hard-coded init to N configurable steps, adds a start/busy/done handshake, an abort, and an explicit valid strobe in place of high-impedance idle outputs. It sits between the top-level control FSM and the RTC write path.

---
 rtl/rtc_init_sequencer.sv | 62 ++++++
 1 files changed

// File: rtl/rtc_init_sequencer.sv
// rtc_init_sequencer: replays a register address/data table, one entry per HOLD clocks
module rtc_init_sequencer #(
   parameter int STEPS  = 2,
   parameter int HOLD   = 37,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter logic [STEPS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = 32'h0200_0210
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                abort,
   output logic                                busy,
   output logic                                done,
   output logic                                valid,
   output logic [ADDR_W-1:0]                   address,
   output logic [DATA_W-1:0]                   data_mod,
   output logic [(STEPS > 1 ? $clog2(STEPS) : 1)-1:0] step
);
   localparam int EW = ADDR_W + DATA_W;
   localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
   localparam int CW = $clog2(HOLD + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t        state;
   logic [SW-1:0] idx;
   logic [CW-1:0] cnt;
   logic [EW-1:0] tbl [STEPS];
   for (genvar g = 0; g < STEPS; g++) begin : g_tbl
      assign tbl[g] = INIT_TABLE[g*EW +: EW];
   end
   assign step = idx;
   always_ff @(posedge clk) begin
      if (!reset || abort) begin
         state               <= IDLE;
         {busy, done, valid} <= '0;
         {address, data_mod} <= '0;
         idx                 <= '0;
         cnt                 <= '0;
      end else if (state == IDLE) begin
         done <= 1'b0;
         if (start) begin
            state               <= RUN;
            {busy, valid}       <= 2'b11;
            {address, data_mod} <= tbl[0];
            idx                 <= '0;
            cnt                 <= '0;
         end
      end else if (cnt != CW'(HOLD - 1)) begin
         cnt <= cnt + 1'b1;
      end else if (idx != SW'(STEPS - 1)) begin
         cnt                 <= '0;
         idx                 <= idx + 1'b1;
         {address, data_mod} <= tbl[idx + 1'b1];
      end else begin
         state               <= IDLE;
         {busy, done, valid} <= 3'b010;
         {address, data_mod} <= '0;
         idx                 <= '0;
         cnt                 <= '0;
      end
   end
endmodule
